// File: rtl/qgate_pkg.sv
// Shared types, constants and the rounding helper for the quantum gate datapath.
// Build with GATE_SAT_EN defined to saturate rounded results instead of wrapping.
package qgate_pkg;
  localparam int W         = 16;
  localparam int FRAC      = 14;
  localparam int ONE       = 16384;
  localparam int INV_SQRT2 = 11585;

  typedef logic signed [W-1:0]   amp_t;
  typedef logic signed [W:0]     sum_t;
  typedef logic signed [2*W+1:0] wide_t;

  typedef struct packed {
    amp_t re;
    amp_t im;
  } cplx_t;

  typedef enum logic [1:0] {OP_PASS, OP_H, OP_CNOT, OP_PHASE} op_e;

  // Round half up, drop FRAC bits, then clamp or wrap back to W bits.
  function automatic amp_t round_shift(input wide_t x);
    wide_t t;
    t = (x + wide_t'(2**(FRAC-1))) >>> FRAC;
`ifdef GATE_SAT_EN
    if (t > wide_t'(2**(W-1)-1))
      t = wide_t'(2**(W-1)-1);
    else if (t < -wide_t'(2**(W-1)))
      t = -wide_t'(2**(W-1));
`endif
    return amp_t'(t);
  endfunction
endpackage

// File: rtl/qgate_cmul.sv
// Combinational complex multiply y = a * w with Q2.14 rounding (PHASE path).
module qgate_cmul import qgate_pkg::*; (
  input  logic signed [W-1:0] ar,
  input  logic signed [W-1:0] ai,
  input  logic signed [W-1:0] wr,
  input  logic signed [W-1:0] wi,
  output logic signed [W-1:0] yr,
  output logic signed [W-1:0] yi
);
  wide_t pr, pi;

  always_comb begin
    pr = wide_t'(ar) * wide_t'(wr) - wide_t'(ai) * wide_t'(wi);
    pi = wide_t'(ar) * wide_t'(wi) + wide_t'(ai) * wide_t'(wr);
    yr = round_shift(pr);
    yi = round_shift(pi);
  end
endmodule

// File: rtl/qgate_unit.sv
// Single-issue gate datapath: PASS / H / CNOT / PHASE on one amplitude pair per cycle,
// one cycle of latency. GATE_SAT_EN selects saturating rounding for H and PHASE.
module qgate_unit import qgate_pkg::*; (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [1:0]         op,
  input  logic               ctrl_bit,
  input  logic signed [W-1:0] ar,
  input  logic signed [W-1:0] ai,
  input  logic signed [W-1:0] br,
  input  logic signed [W-1:0] bi,
  input  logic signed [W-1:0] cos_theta,
  input  logic signed [W-1:0] sin_theta,
  output logic               out_valid,
  output logic signed [W-1:0] out0r,
  output logic signed [W-1:0] out0i,
  output logic signed [W-1:0] out1r,
  output logic signed [W-1:0] out1i
);
  cplx_t a, b, n0, n1, r0, r1, ph;
  sum_t  sr, si, dr, di;

  assign a = '{re: ar, im: ai};
  assign b = '{re: br, im: bi};

  qgate_cmul u_cmul (
    .ar (ar),
    .ai (ai),
    .wr (cos_theta),
    .wi (sin_theta),
    .yr (ph.re),
    .yi (ph.im)
  );

  // Sums and differences need W+1 bits so -32768 operands cannot overflow.
  always_comb begin
    sr = sum_t'(ar) + sum_t'(br);
    si = sum_t'(ai) + sum_t'(bi);
    dr = sum_t'(ar) - sum_t'(br);
    di = sum_t'(ai) - sum_t'(bi);
    n0 = a;
    n1 = b;
    case (op_e'(op))
      OP_H: begin
        n0.re = round_shift(wide_t'(sr) * wide_t'(INV_SQRT2));
        n0.im = round_shift(wide_t'(si) * wide_t'(INV_SQRT2));
        n1.re = round_shift(wide_t'(dr) * wide_t'(INV_SQRT2));
        n1.im = round_shift(wide_t'(di) * wide_t'(INV_SQRT2));
      end
      OP_CNOT: begin
        if (ctrl_bit) begin
          n0 = b;
          n1 = a;
        end
      end
      OP_PHASE: n0 = ph;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      r0        <= '0;
      r1        <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        r0 <= n0;
        r1 <= n1;
      end
    end
  end

  assign out0r = r0.re;
  assign out0i = r0.im;
  assign out1r = r1.re;
  assign out1i = r1.im;
endmodule

// File: tb/tb_qgate_unit.sv
// Self-checking bench for qgate_unit: directed vector table, scoreboard queue,
// and a random back-to-back burst checked against an integer reference model.
module tb_qgate_unit;
  logic               clk, rst, in_valid, ctrl_bit, out_valid;
  logic [1:0]         op;
  logic signed [15:0] ar, ai, br, bi, cos_theta, sin_theta;
  logic signed [15:0] out0r, out0i, out1r, out1i;

  qgate_unit dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .op(op), .ctrl_bit(ctrl_bit),
    .ar(ar), .ai(ai), .br(br), .bi(bi),
    .cos_theta(cos_theta), .sin_theta(sin_theta),
    .out_valid(out_valid), .out0r(out0r), .out0i(out0i), .out1r(out1r), .out1i(out1i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit r; bit iv; int op; bit cb;
    int ar, ai, br, bi, c, s;
    bit ev; int e0r, e0i, e1r, e1i;
  } vec_t;

  typedef struct { bit ev; int e0r, e0i, e1r, e1i; } exp_t;

  exp_t sb[$];
  exp_t last;
  vec_t tbl[12];
  int   n_tests = 0, n_fail = 0, vec_no = 0;

`ifdef GATE_SAT_EN
  localparam int PH_SAT = 32767;
  localparam int H_POS  = 32767;
  localparam int H_NEG  = -32768;
`else
  localparam int PH_SAT = -1;
  localparam int H_POS  = -19197;
  localparam int H_NEG  = 19196;
`endif

  function automatic vec_t mk(bit r, bit iv, int op_v, bit cb,
                              int a_r, int a_i, int b_r, int b_i, int c, int s,
                              bit ev, int e0r, int e0i, int e1r, int e1i);
    vec_t v;
    v.r = r; v.iv = iv; v.op = op_v; v.cb = cb;
    v.ar = a_r; v.ai = a_i; v.br = b_r; v.bi = b_i; v.c = c; v.s = s;
    v.ev = ev; v.e0r = e0r; v.e0i = e0i; v.e1r = e1r; v.e1i = e1i;
    return v;
  endfunction

  function automatic int rs_m(longint x);
    longint t;
    t = (x + 64'sd8192) >>> 14;
`ifdef GATE_SAT_EN
    if (t > 32767) t = 32767;
    if (t < -32768) t = -32768;
`else
    t = t & 64'hFFFF;
    if (t > 32767) t = t - 65536;
`endif
    return int'(t);
  endfunction

  // Reference model fills in expected outputs for a random vector.
  function automatic vec_t model(vec_t v, exp_t prev);
    vec_t m = v;
    m.ev = v.iv && !v.r;
    m.e0r = prev.e0r; m.e0i = prev.e0i; m.e1r = prev.e1r; m.e1i = prev.e1i;
    if (v.r) begin
      m.e0r = 0; m.e0i = 0; m.e1r = 0; m.e1i = 0;
    end else if (v.iv) begin
      m.e0r = v.ar; m.e0i = v.ai; m.e1r = v.br; m.e1i = v.bi;
      case (v.op)
        1: begin
          m.e0r = rs_m((longint'(v.ar) + v.br) * 11585);
          m.e0i = rs_m((longint'(v.ai) + v.bi) * 11585);
          m.e1r = rs_m((longint'(v.ar) - v.br) * 11585);
          m.e1i = rs_m((longint'(v.ai) - v.bi) * 11585);
        end
        2: if (v.cb) begin
          m.e0r = v.br; m.e0i = v.bi; m.e1r = v.ar; m.e1i = v.ai;
        end
        3: begin
          m.e0r = rs_m(longint'(v.ar) * v.c - longint'(v.ai) * v.s);
          m.e0i = rs_m(longint'(v.ar) * v.s + longint'(v.ai) * v.c);
        end
        default: ;
      endcase
    end
    return m;
  endfunction

  task automatic chk(string nm, int got, int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL vec%0d %s got %0d want %0d", vec_no, nm, got, want);
    end
  endtask

  task automatic apply(vec_t v);
    exp_t e;
    @(negedge clk);
    rst = v.r; in_valid = v.iv; op = 2'(v.op); ctrl_bit = v.cb;
    ar = 16'(v.ar); ai = 16'(v.ai); br = 16'(v.br); bi = 16'(v.bi);
    cos_theta = 16'(v.c); sin_theta = 16'(v.s);
    e.ev = v.ev; e.e0r = v.e0r; e.e0i = v.e0i; e.e1r = v.e1r; e.e1i = v.e1i;
    sb.push_back(e);
    last = e;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("out_valid", int'(out_valid), int'(e.ev));
    chk("out0r", int'(out0r), e.e0r);
    chk("out0i", int'(out0i), e.e0i);
    chk("out1r", int'(out1r), e.e1r);
    chk("out1i", int'(out1i), e.e1i);
    vec_no++;
  endtask

  initial begin
    vec_t v;
    rst = 1'b1; in_valid = 1'b0; op = '0; ctrl_bit = 1'b0;
    ar = '0; ai = '0; br = '0; bi = '0; cos_theta = '0; sin_theta = '0;
    last = '{0, 0, 0, 0, 0};

    tbl[0]  = mk(0,1,1,0, 16384,0, 0,0, 0,0,           1, 11585,0, 11585,0);
    tbl[1]  = mk(0,1,1,0, 0,0, 16384,0, 0,0,           1, 11585,0, -11585,0);
    tbl[2]  = mk(0,1,2,1, 100,-5, 7,9, 0,0,            1, 7,9, 100,-5);
    tbl[3]  = mk(0,1,2,0, 100,-5, 7,9, 0,0,            1, 100,-5, 7,9);
    tbl[4]  = mk(0,0,1,1, 1,1, 2,2, 0,0,               0, 100,-5, 7,9);
    tbl[5]  = mk(0,1,3,0, 16384,0, 3,4, 0,16384,       1, 0,16384, 3,4);
    tbl[6]  = mk(0,1,3,0, 32767,-32768, 1,2, 16384,16384, 1, PH_SAT,-1, 1,2);
    tbl[7]  = mk(0,1,1,0, 32767,0, 32767,0, 0,0,       1, H_POS,0, 0,0);
    tbl[8]  = mk(0,1,3,0, -32768,12345, -32768,-32768, 16384,0, 1, -32768,12345, -32768,-32768);
    tbl[9]  = mk(0,1,0,1, -32768,32767, -1,1, 5,5,     1, -32768,32767, -1,1);
    tbl[10] = mk(0,1,1,0, -32768,-32768, -32768,-32768, 0,0, 1, H_NEG,H_NEG, 0,0);
    tbl[11] = mk(0,1,2,1, 5,6, -7,-8, 0,0,             1, -7,-8, 5,6);

    // Reset held two cycles with in_valid high: reset must win.
    apply(mk(1,1,1,0, 1000,2000,3000,4000, 0,0, 0, 0,0,0,0));
    apply(mk(1,1,3,0, 1000,2000,3000,4000, 9,9, 0, 0,0,0,0));
    apply(mk(0,0,1,0, 1000,2000,3000,4000, 0,0, 0, 0,0,0,0));

    for (int i = 0; i < 12; i++) apply(tbl[i]);

    // Random back-to-back traffic with occasional idle cycles.
    for (int i = 0; i < 60; i++) begin
      v.r  = 1'b0;
      v.iv = ($urandom_range(0, 3) != 0);
      v.op = int'($urandom_range(0, 3));
      v.cb = 1'($urandom_range(0, 1));
      v.ar = int'($urandom_range(0, 65535)) - 32768;
      v.ai = int'($urandom_range(0, 65535)) - 32768;
      v.br = int'($urandom_range(0, 65535)) - 32768;
      v.bi = int'($urandom_range(0, 65535)) - 32768;
      v.c  = int'($urandom_range(0, 32768)) - 16384;
      v.s  = int'($urandom_range(0, 32768)) - 16384;
      apply(model(v, last));
    end

    // Mid-stream reset clears data and valid.
    apply(mk(1,1,2,1, 11,22,33,44, 0,0, 0, 0,0,0,0));
    apply(mk(0,0,2,1, 11,22,33,44, 0,0, 0, 0,0,0,0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/qgate_unit.md
Name: qgate_unit

Overview:
Registered single-issue quantum gate datapath for the state-vector engine. It consumes one amplitude pair (a, b) per cycle and applies one of four operations: pass-through, Hadamard, controlled-NOT, or single-amplitude phase rotation. It sits between state memory read ports and the scheduler's write-back path, and replaces the separate combinational H/CNOT/phase gate blocks with one pipelined unit.

Parameters:
W, 16, amplitude/trig word width, signed two's complement
FRAC, 14, fractional bits (Q2.14; 1.0 = 16384)
INV_SQRT2, 11585, round(2^FRAC/sqrt(2)) Hadamard coefficient

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
in_valid  in  1  operand pair valid this cycle
op  in  2  0=PASS, 1=H, 2=CNOT, 3=PHASE
ctrl_bit  in  1  CNOT control qubit value for this pair
ar, ai  in  W  amplitude a, real/imag (signed)
br, bi  in  W  amplitude b, real/imag (signed)
cos_theta, sin_theta  in  W  phase factor, Q2.14 signed
out_valid  out  1  results valid
out0r, out0i  out  W  result for a slot
out1r, out1i  out  W  result for b slot

Behaviour:
- One clock and one reset. Reset is synchronous and active-high (rst sampled on the rising edge of clk). rst has priority over in_valid.
- Reset values: out_valid=0; all out* = 0.
- Latency: exactly 1 cycle. Inputs sampled at edge N with in_valid=1 appear on the outputs after edge N, with out_valid=1. Throughput is 1 pair per cycle, with no stall or backpressure.
- in_valid=0: out_valid=0 next cycle. Data outputs hold their previous values.
- PASS: out0=a, out1=b.
- H: out0 = rs((a+b)*INV_SQRT2), out1 = rs((a-b)*INV_SQRT2). Applied per real and imaginary component. Sums and differences use W+1 bits; products use at least 2W+2 bits.
- CNOT: ctrl_bit=1 gives out0=b, out1=a (swap). ctrl_bit=0 gives pass-through.
- PHASE: out0 = a*(cos + i*sin).
  - out0r = rs(ar*cos - ai*sin)
  - out0i = rs(ar*sin + ai*cos)
  - out1 = b unchanged
  - Accumulation uses at least 2W+1 bits.
- rs(x): add 2^(FRAC-1), then arithmetic shift right by FRAC (round half up), then reduce to W bits per the GATE_SAT_EN rules.
- Boundaries:
  - -32768 inputs must not overflow intermediates.
  - a=b gives H out1 = 0 exactly.
  - cos=16384 with sin=0 gives a bit-exact passthrough.

Optional Feature:
GATE_SAT_EN
- Defined: rs() saturates to [-2^(W-1), 2^(W-1)-1].
- Undefined: rs() truncates to the low W bits (two's-complement wrap).
- PASS and CNOT are unaffected either way.

Decomposition:
- Package qgate_pkg holds:
  - amp_t (signed W-bit) and the cplx_t struct {re, im}
  - FRAC, ONE=16384, INV_SQRT2
  - op enum op_e {OP_PASS, OP_H, OP_CNOT, OP_PHASE}
  - function round_shift (rounding plus sat/wrap, conditioned on GATE_SAT_EN)
- Sub-module qgate_cmul is a combinational complex multiply with rounding, used for PHASE.

Test Plan:
- rst=1 for 2 cycles, then rst=0 with in_valid=0 -> out_valid=0, all outputs 0.
- H, a=16384+0i, b=0 -> next cycle out0r=11585, out1r=11585, imag parts 0, out_valid=1.
- H, a=0, b=16384 -> out0r=11585, out1r=-11585.
- CNOT, a=(100,-5), b=(7,9): ctrl_bit=1 -> out0=(7,9), out1=(100,-5); ctrl_bit=0 -> unchanged.
- PHASE, cos=0, sin=16384, a=(16384,0), b=(3,4) -> out0=(0,16384), out1=(3,4).
- PHASE, cos=sin=16384, a=(32767,-32768) -> out0r=32767 with GATE_SAT_EN, -1 without. H with a=b=(32767,0) -> out0r=32767 with GATE_SAT_EN, -19197 without.
